// File: rtl/sram_like_responder.sv
// sram_like_responder: memory-side responder for the SRAM-like request bus.
// Requests are accepted with a one-cycle addr_ok pulse into a 2-entry in-order
// queue. Each request completes with a one-cycle data_ok pulse after LATENCY
// cycles against an internal word-addressed RAM with byte enables.
//
// Handshake: a request is transferred at a rising edge where req=1, addr_ok=0
// and the queue holds fewer than two entries (counted before any same-edge
// pop); addr_ok is then high for exactly the following cycle, during which req
// is ignored because the initiator drops it on addr_ok. Every accepted request
// produces exactly one data_ok pulse, in acceptance order; rdata is valid in
// the data_ok cycle of a read and holds until the next read completes.
//
// LATENCY must lie in 1..15 (the service counter is 4 bits wide).
module sram_like_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [3:0]  select,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int         DEPTH      = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_RELOAD = 4'(LATENCY - 1);

  typedef struct packed {
    logic                  wr;
    logic [3:0]            sel;
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           wdata;
  } entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [1:0]  count;
  entry_t      q_head;
  entry_t      q_tail;
  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        pop;
  logic [1:0]  count_next;
  entry_t      new_entry;
  logic        unused_addr_bits;

  // Accept uses the occupancy before any pop at the same edge.
  assign accept     = req && !addr_ok && (count < 2'd2);
  // The head entry executes at the edge where the service counter has expired.
  assign pop        = (state == BUSY) && (cnt == 4'd0);
  assign count_next = count + {1'b0, accept} - {1'b0, pop};
  assign new_entry  = '{wr: wr, sel: select, idx: addr[ADDR_WIDTH+1:2], wdata: wdata};

  // Byte-offset and upper address bits do not select a word (addresses alias).
  assign unused_addr_bits = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

  // Queue storage: shift tail into head on pop, new entry into first free slot.
  always_ff @(posedge clk) begin
    if (pop) begin
      q_head <= q_tail;
    end
    if (accept) begin
      if ((count == 2'd0) || pop) begin
        q_head <= new_entry;
      end else begin
        q_tail <= new_entry;
      end
    end
  end

  // RAM byte writes from the head entry; suppressed while in reset.
  always_ff @(posedge clk) begin
    if (!rst && pop && q_head.wr) begin
      for (int i = 0; i < 4; i++) begin
        if (q_head.sel[i]) begin
          mem[q_head.idx][8*i +: 8] <= q_head.wdata[8*i +: 8];
        end
      end
    end
  end

  // Control: handshake pulses, occupancy, service FSM and read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_ok <= 1'b0;
      data_ok <= 1'b0;
      rdata   <= 32'h0;
      count   <= 2'd0;
      state   <= IDLE;
      cnt     <= 4'd0;
    end else begin
      addr_ok <= accept;
      data_ok <= pop;
      count   <= count_next;

      if (pop && !q_head.wr) begin
        rdata <= mem[q_head.idx];
      end

      case (state)
        IDLE: begin
          // An entry arriving at this edge starts its latency window now.
          if (count_next != 2'd0) begin
            cnt   <= CNT_RELOAD;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (count_next != 2'd0) begin
            cnt <= CNT_RELOAD;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Testbench for sram_like_responder. Three instances cover LATENCY 2, 8 and 4;
// the instances not under test are held in reset. Cycle 0 of a sequence is the
// cycle in which the first req is raised.
module tb_sram_like_responder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;

  logic        req   = 1'b0;
  logic        wr    = 1'b0;
  logic [3:0]  sel   = 4'h0;
  logic [31:0] addr  = 32'h0;
  logic [31:0] wdata = 32'h0;

  logic        aok_a, dok_a, aok_b, dok_b, aok_c, dok_c;
  logic [31:0] rd_a, rd_b, rd_c;

  sram_like_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut_a (
    .clk(clk), .rst(rst_a), .req(req), .wr(wr), .select(sel), .addr(addr),
    .wdata(wdata), .addr_ok(aok_a), .data_ok(dok_a), .rdata(rd_a)
  );

  sram_like_responder #(.ADDR_WIDTH(10), .LATENCY(8)) dut_b (
    .clk(clk), .rst(rst_b), .req(req), .wr(wr), .select(sel), .addr(addr),
    .wdata(wdata), .addr_ok(aok_b), .data_ok(dok_b), .rdata(rd_b)
  );

  sram_like_responder #(.ADDR_WIDTH(10), .LATENCY(4)) dut_c (
    .clk(clk), .rst(rst_c), .req(req), .wr(wr), .select(sel), .addr(addr),
    .wdata(wdata), .addr_ok(aok_c), .data_ok(dok_c), .rdata(rd_c)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Request table for a sequence and the observations recorded from it.
  logic        rq_wr    [8];
  logic [3:0]  rq_sel   [8];
  logic [31:0] rq_addr  [8];
  logic [31:0] rq_wdata [8];
  int          aok_cyc  [8];
  int          dok_cyc  [8];
  logic [31:0] dok_rd   [8];
  int          n_aok;
  int          n_dok;

  function automatic logic get_aok(input int w);
    case (w)
      0:       return aok_a;
      1:       return aok_b;
      default: return aok_c;
    endcase
  endfunction

  function automatic logic get_dok(input int w);
    case (w)
      0:       return dok_a;
      1:       return dok_b;
      default: return dok_c;
    endcase
  endfunction

  function automatic logic [31:0] get_rd(input int w);
    case (w)
      0:       return rd_a;
      1:       return rd_b;
      default: return rd_c;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] d);
    rq_wr[i]    = w;
    rq_sel[i]   = s;
    rq_addr[i]  = a;
    rq_wdata[i] = d;
  endtask

  // Issues n requests to instance w and records addr_ok/data_ok cycles and
  // rdata at each data_ok. With hold=0 req drops in addr_ok cycles (as the
  // real initiator does); with hold=1 req stays high with the next request.
  // Called and returns at 1 time unit after a rising edge.
  task automatic run_seq(input int w, input int n, input bit hold, input int max_cyc);
    int sent;
    sent  = 0;
    n_aok = 0;
    n_dok = 0;
    for (int i = 0; i < 8; i++) begin
      aok_cyc[i] = -1;
      dok_cyc[i] = -1;
      dok_rd[i]  = 'x;
    end
    for (int c = 0; c < max_cyc; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (get_aok(w)) begin
        if (n_aok < 8) aok_cyc[n_aok] = c;
        n_aok++;
        sent++;
      end
      if (get_dok(w)) begin
        if (n_dok < 8) begin
          dok_cyc[n_dok] = c;
          dok_rd[n_dok]  = get_rd(w);
        end
        n_dok++;
      end
      if (n_dok >= n) begin
        req = 1'b0;
        break;
      end
      if (sent < n && !(get_aok(w) && !hold)) begin
        req   = 1'b1;
        wr    = rq_wr[sent];
        sel   = rq_sel[sent];
        addr  = rq_addr[sent];
        wdata = rq_wdata[sent];
      end else begin
        req = 1'b0;
      end
    end
    req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [2:0]  ok_bits;
    logic [31:0] rds [3];
    ok_bits = {aok_a | dok_a, aok_b | dok_b, aok_c | dok_c};
    rds[0] = rd_a; rds[1] = rd_b; rds[2] = rd_c;
    n_cmp++;
    if (ok_bits !== 3'b000) begin
      n_fail++; $display("FAIL reset_handshake: got %b want 000", ok_bits);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (rds[i] !== 32'h0) begin
        n_fail++; $display("FAIL reset_rdata[%0d]: got %h want 00000000", i, rds[i]);
      end
    end
    rst_a = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_word_write_read;
    set_req(0, 1'b1, 4'hF, 32'h0000_0010, 32'h1122_3344);
    run_seq(0, 1, 1'b0, 20);
    n_cmp++;
    if (aok_cyc[0] !== 1) begin
      n_fail++; $display("FAIL word_wr_aok_cycle: got %0d want 1", aok_cyc[0]);
    end
    n_cmp++;
    if (dok_cyc[0] !== 3) begin
      n_fail++; $display("FAIL word_wr_dok_cycle: got %0d want 3", dok_cyc[0]);
    end
    n_cmp++;
    if (n_dok !== 1) begin
      n_fail++; $display("FAIL word_wr_dok_count: got %0d want 1", n_dok);
    end
    set_req(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
    run_seq(0, 1, 1'b0, 20);
    n_cmp++;
    if (dok_cyc[0] !== 3) begin
      n_fail++; $display("FAIL word_rd_dok_cycle: got %0d want 3", dok_cyc[0]);
    end
    n_cmp++;
    if (dok_rd[0] !== 32'h1122_3344) begin
      n_fail++; $display("FAIL word_rd_data: got %h want 11223344", dok_rd[0]);
    end
  endtask

  task automatic test_byte_write;
    set_req(0, 1'b1, 4'b0010, 32'h0000_0010, 32'h0000_AB00);
    run_seq(0, 1, 1'b0, 20);
    set_req(0, 1'b0, 4'b0001, 32'h0000_0010, 32'h0);
    run_seq(0, 1, 1'b0, 20);
    n_cmp++;
    if (dok_rd[0] !== 32'h1122_AB44) begin
      n_fail++; $display("FAIL byte_rd_data: got %h want 1122ab44", dok_rd[0]);
    end
    // select=0 completes, changes nothing, and leaves rdata as it was.
    set_req(0, 1'b1, 4'b0000, 32'h0000_0010, 32'hFFFF_FFFF);
    run_seq(0, 1, 1'b0, 20);
    n_cmp++;
    if (n_dok !== 1 || dok_cyc[0] !== 3) begin
      n_fail++; $display("FAIL sel0_dok: got count %0d cycle %0d want 1 / 3", n_dok, dok_cyc[0]);
    end
    n_cmp++;
    if (dok_rd[0] !== 32'h1122_AB44) begin
      n_fail++; $display("FAIL sel0_rdata_hold: got %h want 1122ab44", dok_rd[0]);
    end
    set_req(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
    run_seq(0, 1, 1'b0, 20);
    n_cmp++;
    if (dok_rd[0] !== 32'h1122_AB44) begin
      n_fail++; $display("FAIL sel0_rd_data: got %h want 1122ab44", dok_rd[0]);
    end
  endtask

  task automatic test_back_to_back;
    set_req(0, 1'b1, 4'hF, 32'h0000_0014, 32'h5566_7788);
    run_seq(0, 1, 1'b0, 20);
    set_req(0, 1'b0, 4'hF, 32'h0000_0010, 32'h0);
    set_req(1, 1'b0, 4'hF, 32'h0000_0014, 32'h0);
    run_seq(0, 2, 1'b0, 30);
    n_cmp++;
    if (aok_cyc[0] !== 1 || aok_cyc[1] !== 3) begin
      n_fail++; $display("FAIL b2b_aok_cycles: got %0d,%0d want 1,3", aok_cyc[0], aok_cyc[1]);
    end
    n_cmp++;
    if (dok_cyc[0] !== 3 || dok_cyc[1] !== 5) begin
      n_fail++; $display("FAIL b2b_dok_cycles: got %0d,%0d want 3,5", dok_cyc[0], dok_cyc[1]);
    end
    n_cmp++;
    if (dok_rd[0] !== 32'h1122_AB44) begin
      n_fail++; $display("FAIL b2b_rdata0: got %h want 1122ab44", dok_rd[0]);
    end
    n_cmp++;
    if (dok_rd[1] !== 32'h5566_7788) begin
      n_fail++; $display("FAIL b2b_rdata1: got %h want 55667788", dok_rd[1]);
    end
  endtask

  task automatic test_alias;
    set_req(0, 1'b1, 4'hF, 32'h0000_1004, 32'hCAFE_F00D);
    run_seq(0, 1, 1'b0, 20);
    set_req(0, 1'b0, 4'hF, 32'h0000_0004, 32'h0);
    run_seq(0, 1, 1'b0, 20);
    n_cmp++;
    if (dok_rd[0] !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL alias_rd_data: got %h want cafef00d", dok_rd[0]);
    end
    // Neighbouring word must be untouched by the aliased write.
    set_req(0, 1'b0, 4'hF, 32'h0000_0014, 32'h0);
    run_seq(0, 1, 1'b0, 20);
    n_cmp++;
    if (dok_rd[0] !== 32'h5566_7788) begin
      n_fail++; $display("FAIL alias_neighbour: got %h want 55667788", dok_rd[0]);
    end
  endtask

  task automatic test_full_queue;
    set_req(0, 1'b1, 4'hF, 32'h0000_0000, 32'hA0A0_0001);
    set_req(1, 1'b1, 4'hF, 32'h0000_0004, 32'hB0B0_0002);
    set_req(2, 1'b1, 4'hF, 32'h0000_0008, 32'hC0C0_0003);
    run_seq(1, 3, 1'b1, 60);
    n_cmp++;
    if (n_dok !== 3) begin
      n_fail++; $display("FAIL full_dok_count: got %0d want 3", n_dok);
    end
    n_cmp++;
    if (aok_cyc[0] !== 1 || aok_cyc[1] !== 3 || aok_cyc[2] !== 10) begin
      n_fail++; $display("FAIL full_aok_cycles: got %0d,%0d,%0d want 1,3,10",
                         aok_cyc[0], aok_cyc[1], aok_cyc[2]);
    end
    n_cmp++;
    if (dok_cyc[0] !== 9 || dok_cyc[1] !== 17 || dok_cyc[2] !== 25) begin
      n_fail++; $display("FAIL full_dok_cycles: got %0d,%0d,%0d want 9,17,25",
                         dok_cyc[0], dok_cyc[1], dok_cyc[2]);
    end
    set_req(0, 1'b0, 4'hF, 32'h0000_0008, 32'h0);
    set_req(1, 1'b0, 4'hF, 32'h0000_0000, 32'h0);
    run_seq(1, 2, 1'b0, 60);
    n_cmp++;
    if (dok_rd[0] !== 32'hC0C0_0003 || dok_rd[1] !== 32'hA0A0_0001) begin
      n_fail++; $display("FAIL full_readback: got %h,%h want c0c00003,a0a00001",
                         dok_rd[0], dok_rd[1]);
    end
  endtask

  task automatic test_reset_mid;
    int dok_seen;
    // Known pre-write contents, also leaves rdata non-zero before the reset.
    set_req(0, 1'b1, 4'hF, 32'h0000_0020, 32'h0102_0304);
    run_seq(2, 1, 1'b0, 20);
    set_req(0, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
    run_seq(2, 1, 1'b0, 20);
    n_cmp++;
    if (dok_rd[0] !== 32'h0102_0304) begin
      n_fail++; $display("FAIL rstmid_preload: got %h want 01020304", dok_rd[0]);
    end
    dok_seen = 0;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      if (dok_c) dok_seen++;
      if (c == 1) begin
        n_cmp++;
        if (aok_c !== 1'b1) begin
          n_fail++; $display("FAIL rstmid_aok: got %b want 1", aok_c);
        end
      end
      if (c == 4) begin
        n_cmp++;
        if ({aok_c, dok_c, rd_c} !== 34'h0) begin
          n_fail++; $display("FAIL rstmid_outputs: got aok=%b dok=%b rdata=%h want 0,0,0",
                             aok_c, dok_c, rd_c);
        end
      end
      req   = (c == 0);
      wr    = 1'b1;
      sel   = 4'hF;
      addr  = 32'h0000_0020;
      wdata = 32'hDEAD_BEEF;
      rst_c = (c == 3);
    end
    req = 1'b0;
    n_cmp++;
    if (dok_seen !== 0) begin
      n_fail++; $display("FAIL rstmid_no_dok: got %0d pulses want 0", dok_seen);
    end
    set_req(0, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
    run_seq(2, 1, 1'b0, 20);
    n_cmp++;
    if (dok_rd[0] !== 32'h0102_0304) begin
      n_fail++; $display("FAIL rstmid_ram_kept: got %h want 01020304", dok_rd[0]);
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_word_write_read();
    test_byte_write();
    test_back_to_back();
    test_alias();

    rst_a = 1'b1;
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    test_full_queue();

    rst_b = 1'b1;
    rst_c = 1'b0;
    @(posedge clk);
    #1;
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sram_like_responder.md
# sram_like_responder

On-chip responder for the SRAM-like request/handshake bus that the CPU's data-memory adapter drives (req/wr/select/addr/wdata out; addr_ok/data_ok/rdata back). It stands in as the memory side of that bus for synthesis on small RAMs and for simulation of the memory stage. Requests are accepted with a registered one-cycle addr_ok pulse and queued in a 2-entry in-order queue. Each request completes with a one-cycle data_ok pulse after a programmable latency against an internal word-addressed RAM with byte enables.

## Interface
- ADDR_WIDTH, default 10: word-index bits. The RAM holds 2^ADDR_WIDTH 32-bit words.
- LATENCY, default 2, legal range 1..15: minimum cycles from addr_ok to data_ok, and minimum spacing between data_ok pulses.
- clk  in  1: clock. Rising edge is the only active edge.
- rst  in  1: reset. Synchronous, active-high (`RstEnable`).
- req  in  1: request valid.
- wr  in  1: 1 = write, 0 = read.
- select  in  4: byte enables. select[i] qualifies wdata[8i+7:8i].
- addr  in  32: byte address.
- wdata  in  32: write data.
- addr_ok  out  1: request accepted. Registered, one-cycle pulse.
- data_ok  out  1: oldest accepted request has completed. Registered, one-cycle pulse.
- rdata  out  32: read data. Valid in the data_ok cycle of a read.

## Operation
- Reset: addr_ok=0, data_ok=0, rdata=0, queue empty (count=0), service FSM in IDLE, latency counter=0. RAM contents are not reset.
- Accept rule, evaluated at each edge: accept iff req=1 && addr_ok=0 && count<2.
  - count is the value before any pop at the same edge. A pop in the same cycle does not free a slot early.
  - On accept: enqueue {wr, select, addr, wdata} as sampled in that cycle, and drive addr_ok=1 for the next cycle only.
  - req is ignored in any cycle where addr_ok=1, because the initiator drops req combinationally on addr_ok.
  - The fastest accept rate is therefore one request per 2 cycles.
- Word index = addr[ADDR_WIDTH+1:2].
  - addr[1:0] is ignored.
  - Upper address bits are ignored, so addresses alias modulo 2^(ADDR_WIDTH+2).
- Service FSM, two states:
  - IDLE: if count>0, load cnt=LATENCY-1 and go to BUSY.
  - BUSY: while cnt>0, decrement cnt. When cnt==0:
    - drive data_ok=1 for the next cycle;
    - execute the head entry at that edge;
    - pop the head;
    - if another entry remains (including one enqueued at the same edge), reload cnt=LATENCY-1 and stay in BUSY; otherwise go to IDLE.
- Execution of the head entry:
  - Write: for each i with select[i]=1, RAM[idx] byte i <= wdata byte i. select=4'b0000 still completes with data_ok and leaves RAM unchanged. rdata is unchanged.
  - Read: rdata <= RAM[idx], the full word regardless of select, including writes from earlier entries. rdata holds its value until the next read completes.
- Completion order equals acceptance order. Each accepted request yields exactly one data_ok.
- rst asserted mid-operation:
  - queued and in-service entries are discarded;
  - no data_ok is ever issued for them;
  - entries not yet executed do not modify the RAM.

## Timing
- Isolated request, req high in cycle 0: addr_ok=1 in cycle 1; data_ok=1 in cycle 1+LATENCY.
- General rule, with A = addr_ok cycle and D_prev = previous data_ok cycle: data_ok cycle D = max(A, D_prev) + LATENCY.
- A request sampled in the same cycle as a data_ok is legal and is accepted if count<2 before the pop.
- addr_ok and data_ok may be high in the same cycle.
- All outputs are registered. There are no combinational paths from any input to any output.

## Test plan
Default parameters throughout (ADDR_WIDTH=10, LATENCY=2) unless stated.
1. **Word write then read.** Write addr=0x00000010, wdata=0x11223344, select=4'b1111, req in cycle 0. Then read the same address.
   - Write: addr_ok in cycle 1, data_ok in cycle 3.
   - Read: data_ok with rdata=0x11223344.
2. **Byte write.** After scenario 1, write select=4'b0010, wdata=0x0000AB00 to 0x10, then read.
   - Required: rdata=0x1122AB44.
   - A further write with select=0 followed by a read still returns 0x1122AB44.
3. **Back-to-back reads.** Initiator re-raises req immediately after each addr_ok (reads at 0x10, then 0x14).
   - addr_ok in cycles 1 and 3; data_ok in cycles 3 and 5, in order.
   - rdata in cycle 5 = contents of word 5.
4. **Full queue.** LATENCY=8, req held continuously for 3 requests.
   - addr_ok in cycles 1 and 3.
   - Third request waits; data_ok #1 in cycle 9. The third request is accepted at the edge after count drops below 2, i.e. addr_ok in cycle 10.
   - data_ok #2 in cycle 17, #3 in cycle 25.
5. **Reset mid-operation.** LATENCY=4, write 0xDEADBEEF to 0x20; rst asserted in cycle 3 (after addr_ok, before data_ok).
   - No data_ok ever occurs.
   - addr_ok, data_ok and rdata read 0 from the cycle after reset.
   - A subsequent read of 0x20 returns the pre-write contents.
6. **Aliasing.** ADDR_WIDTH=10, write 0xCAFEF00D to 0x00001004, then read 0x00000004.
   - Required: rdata=0xCAFEF00D.
